// File: rtl/cordic.sv
// Rotation-mode CORDIC, fully pipelined: one quadrant pre-rotation stage
// followed by STAGES micro-rotation stages. Accepts a new sample every clock.
//
// Handshake: start qualifies x_start/y_start/angle on the sampling edge and
// travels alongside the data; done is that same bit STAGES+1 clocks later and
// marks cosine/sine as meaningful. There is no ready: the pipeline never stalls
// and processes every cycle's inputs regardless of start.
module cordic #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_start,
  input  logic signed [WIDTH-1:0] y_start,
  input  logic        [31:0]      angle,
  output logic signed [WIDTH-1:0] cosine,
  output logic signed [WIDTH-1:0] sine,
  output logic                    done
);

  // Two guard bits absorb the ~1.647 gain growth of the rotation.
  localparam int XW   = WIDTH + 2;
  localparam int LAST = STAGES - 1;

  // atan(2^-i) as a binary angle where 2^32 is a full turn.
  localparam logic [31:0] ATAN [0:30] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1
  };

  logic signed [XW-1:0]    xs;
  logic signed [XW-1:0]    ys;
  logic signed [XW-1:0]    x_pre;
  logic signed [XW-1:0]    y_pre;
  logic signed [31:0]      z_pre;
  logic signed [XW-1:0]    x_q [0:STAGES-1];
  logic signed [XW-1:0]    y_q [0:STAGES-1];
  logic signed [31:0]      z_q [0:STAGES-1];
  logic        [STAGES:0]  v_q;
  logic signed [WIDTH-1:0] x_last;
  logic signed [WIDTH-1:0] y_last;
  logic signed [WIDTH-1:0] cos_q;
  logic signed [WIDTH-1:0] sin_q;

  assign xs = {{2{x_start[WIDTH-1]}}, x_start};
  assign ys = {{2{y_start[WIDTH-1]}}, y_start};

  // Quadrant pre-rotation: fold the angle into +-90 degrees by a 90-degree turn.
  always_comb begin
    x_pre = xs;
    y_pre = ys;
    z_pre = angle;
    case (angle[31:30])
      2'b01: begin
        x_pre = -ys;
        y_pre = xs;
        z_pre = angle - 32'h4000_0000;
      end
      2'b10: begin
        x_pre = ys;
        y_pre = -xs;
        z_pre = angle + 32'h4000_0000;
      end
      default: ;
    endcase
  end

  // Final micro-rotation; only the low WIDTH bits leave the block.
  assign x_last = WIDTH'(z_q[LAST][31] ? x_q[LAST] + (y_q[LAST] >>> LAST)
                                       : x_q[LAST] - (y_q[LAST] >>> LAST));
  assign y_last = WIDTH'(z_q[LAST][31] ? y_q[LAST] - (x_q[LAST] >>> LAST)
                                       : y_q[LAST] + (x_q[LAST] >>> LAST));

  // Pipeline registers: pre-rotation stage, iteration stages and the valid chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      v_q   <= '0;
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      x_q[0] <= x_pre;
      y_q[0] <= y_pre;
      z_q[0] <= z_pre;
      for (int i = 0; i < STAGES - 1; i++) begin
        if (z_q[i][31]) begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + ATAN[i];
        end else begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - ATAN[i];
        end
      end
      cos_q <= x_last;
      sin_q <= y_last;
      v_q   <= {v_q[STAGES-1:0], start};
    end
  end

  assign cosine = cos_q;
  assign sine   = sin_q;
  assign done   = v_q[STAGES];

endmodule

// File: tb/tb_cordic.sv
// Bench for cordic: expected rotations from a real-number model are queued as
// samples are driven and compared, with exact latency, as done appears.
module tb_cordic;

  localparam int  WIDTH   = 32;
  localparam int  STAGES  = 30;
  localparam int  LATENCY = STAGES + 1;
  localparam int  X0      = 652032874;
  localparam int  TOL     = 256;
  localparam real K       = 1.646760258121;
  localparam real PI      = 3.14159265358979;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic signed [WIDTH-1:0] x_start;
  logic signed [WIDTH-1:0] y_start;
  logic        [31:0]      angle;
  logic signed [WIDTH-1:0] cosine;
  logic signed [WIDTH-1:0] sine;
  logic                    done;

  int total;
  int bad;
  int cyc;
  int done_cnt;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_sin_q[$];
  logic [31:0]      exp_cyc_q[$];

  cordic #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x_start (x_start),
    .y_start (y_start),
    .angle   (angle),
    .cosine  (cosine),
    .sine    (sine),
    .done    (done)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp,
                           input longint tol);
    longint diff;
    total++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d",
               tag, obs, exp, tol, cyc);
    end
  endtask

  // Ideal rotation scaled by the CORDIC gain.
  task automatic model(input int xs, input int ys, input logic [31:0] ang,
                       output longint ec, output longint es);
    real a;
    a  = real'(ang) * 2.0 * PI / 4294967296.0;
    ec = longint'(K * (real'(xs) * $cos(a) - real'(ys) * $sin(a)));
    es = longint'(K * (real'(xs) * $sin(a) + real'(ys) * $cos(a)));
  endtask

  // Drive one valid sample for one clock; called #1 after a rising edge.
  task automatic send(input int xs, input int ys, input logic [31:0] ang);
    longint ec;
    longint es;
    model(xs, ys, ang, ec, es);
    start   = 1'b1;
    x_start = xs;
    y_start = ys;
    angle   = ang;
    exp_q.push_back(ec[WIDTH-1:0]);
    exp_sin_q.push_back(es[WIDTH-1:0]);
    exp_cyc_q.push_back(32'(cyc + 1 + LATENCY - 1));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * LATENCY && exp_q.size() > 0; n++) idle(1);
    check_val("drain_pending", exp_q.size(), 0, 0);
  endtask

  // Scoreboard: every done must match the oldest queued sample, on its exact cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 1, 0, 0);
      end else begin
        check_val("cosine", longint'(cosine), longint'(signed'(exp_q.pop_front())), TOL);
        check_val("sine", longint'(sine), longint'(signed'(exp_sin_q.pop_front())), TOL);
        check_val("latency", cyc, longint'(exp_cyc_q.pop_front()), 0);
      end
    end
  end

  initial begin
    int cnt_before;
    total    = 0;
    bad      = 0;
    cyc      = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    x_start  = '0;
    y_start  = '0;
    angle    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cosine", cosine, 0, 0);
    check_val("rst_sine", sine, 0, 0);
    check_val("rst_done", done, 0, 0);
    rst = 1'b0;
    idle(2);

    // Angle zero, single pulse
    send(X0, 0, 32'h0);
    drain();

    // Octant and quadrant points, isolated
    send(X0, 0, 32'h2000_0000); idle(3);
    send(X0, 0, 32'h4000_0000); idle(3);
    send(X0, 0, 32'h8000_0000); idle(3);
    send(X0, 0, 32'hC000_0000); idle(3);
    send(X0, 0, 32'd45);
    drain();

    // Streaming: back-to-back samples
    for (int k = 0; k < 8; k++) send(X0, 0, 32'(k) * 32'h1000_0000);
    drain();

    // Gain and other input vectors
    send(0, X0, 32'h4000_0000);
    send(1000000, 0, 32'h0);
    send(-X0, 0, 32'h1234_5678);
    send(0, -X0, 32'hE000_0000);
    drain();

    // Random angles and vectors with random gaps
    for (int k = 0; k < 24; k++) begin
      int xr;
      int yr;
      xr = int'($urandom_range(0, 900000000)) - 450000000;
      yr = int'($urandom_range(0, 900000000)) - 450000000;
      send(xr, yr, $urandom);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset mid-stream discards in-flight samples
    for (int k = 0; k < 6; k++) send(X0, 0, 32'(k) * 32'h0800_0000);
    idle(5);
    rst = 1'b1;
    #1;
    check_val("midrst_cosine", cosine, 0, 0);
    check_val("midrst_sine", sine, 0, 0);
    check_val("midrst_done", done, 0, 0);
    exp_q.delete();
    exp_sin_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_before = done_cnt;
    idle(2 * LATENCY);
    check_val("no_done_after_rst", done_cnt - cnt_before, 0, 0);

    // Pipeline works again after reset
    send(X0, 0, 32'h6000_0000);
    send(X0, 0, 32'hA000_0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
